// File: rtl/addsub_chk_pkg.sv
// addsub_chk_pkg: shared types, constants and the golden arithmetic
// for the adder/subtractor result checker.
package addsub_chk_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int ERR_W = 16;

    typedef struct packed {
        logic [31:0] out;
        logic        carry;
        logic        borrow;
    } exp_t;

    // Operands arrive zero-extended; width selects where the carry bit sits.
    function automatic exp_t calc_expected(input logic [31:0] a, input logic [31:0] b,
                                           input logic mode, input int width);
        logic [32:0] sum;
        exp_t        r;
        sum      = mode ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
        r.out    = sum[31:0];
        r.carry  = !mode && sum[width[5:0]];
        r.borrow = mode && (a < b);
        return r;
    endfunction

endpackage

// File: rtl/addsub_result_checker_if.sv
// addsub_result_checker_if: operand/result stream from the stimulus source
// plus the checker's status and first-fail capture.
interface addsub_result_checker_if #(parameter int WIDTH = 4);
    import addsub_chk_pkg::*;

    logic                 start_in;
    logic                 valid_in;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 mode_in;
    logic [WIDTH-1:0]     out_in;
    logic                 carry_in;
    logic                 borrow_in;
    logic                 busy_out;
    logic                 done_out;
    logic                 pass_out;
    logic [2*WIDTH+1:0]   vec_count_out;
    logic [ERR_W-1:0]     err_count_out;
    logic                 fail_valid_out;
    logic [WIDTH-1:0]     fail_a_out;
    logic [WIDTH-1:0]     fail_b_out;
    logic                 fail_mode_out;

    modport master (
        output start_in, valid_in, a_in, b_in, mode_in, out_in, carry_in, borrow_in,
        input  busy_out, done_out, pass_out, vec_count_out, err_count_out,
               fail_valid_out, fail_a_out, fail_b_out, fail_mode_out
    );

    modport slave (
        input  start_in, valid_in, a_in, b_in, mode_in, out_in, carry_in, borrow_in,
        output busy_out, done_out, pass_out, vec_count_out, err_count_out,
               fail_valid_out, fail_a_out, fail_b_out, fail_mode_out
    );

endinterface

// File: rtl/addsub_ref_model.sv
// addsub_ref_model: combinational golden result for one add/subtract vector.
module addsub_ref_model
    import addsub_chk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_out,
    output logic             o_carry,
    output logic             o_borrow
);

    exp_t w_exp;

    assign w_exp    = calc_expected(32'(i_a), 32'(i_b), i_mode, WIDTH);
    assign o_out    = w_exp.out[WIDTH-1:0];
    assign o_carry  = w_exp.carry;
    assign o_borrow = w_exp.borrow;

endmodule

// File: rtl/addsub_result_checker.sv
// addsub_result_checker: counts vectors/mismatches of an add/sub sweep and captures the first failure.
// Define ADDSUB_CHK_SEQ_EN to also flag vectors arriving out of a/b/mode sweep order.
module addsub_result_checker
    import addsub_chk_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input logic                     clk,
    input logic                     rst_n,
    addsub_result_checker_if.slave  bus
);

    localparam int VW        = 2*WIDTH + 2;
    localparam int VEC_COUNT = 1 << (2*WIDTH + 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [VW-1:0]    r_vec;
    logic [ERR_W-1:0] r_err;
    logic             r_fail_valid;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;
    logic             r_fail_mode;
    logic [WIDTH-1:0] w_out;
    logic             w_carry;
    logic             w_borrow;
    logic             w_seq_err;
    logic             w_accept;
    logic             w_mismatch;
    logic [VW-1:0]    w_vec_next;
    logic             w_last;

    addsub_ref_model #(.WIDTH(WIDTH)) u_ref (
        .i_a      (bus.a_in),
        .i_b      (bus.b_in),
        .i_mode   (bus.mode_in),
        .o_out    (w_out),
        .o_carry  (w_carry),
        .o_borrow (w_borrow)
    );

    // The sweep index equals the low bits of the vector count, which wraps at VEC_COUNT.
`ifdef ADDSUB_CHK_SEQ_EN
    assign w_seq_err = {bus.a_in, bus.b_in, bus.mode_in} != r_vec[VW-2:0];
`else
    assign w_seq_err = 1'b0;
`endif

    assign w_accept   = (r_state == RUN) && bus.valid_in && !bus.start_in;
    assign w_mismatch = (bus.out_in != w_out) || (bus.carry_in != w_carry) ||
                        (bus.borrow_in != w_borrow) || w_seq_err;
    assign w_vec_next = r_vec + 1'b1;
    assign w_last     = w_vec_next == VW'(VEC_COUNT);

    always_comb begin
        w_state_next = r_state;
        if (bus.start_in)
            w_state_next = RUN;
        else if (w_accept && (w_last || (STOP_ON_FAIL && w_mismatch)))
            w_state_next = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec        <= '0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_mode  <= 1'b0;
        end else if (bus.start_in) begin
            r_vec        <= '0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_mode  <= 1'b0;
        end else if (w_accept) begin
            r_vec <= w_vec_next;
            if (w_mismatch) begin
                r_err <= r_err + ERR_W'(~&r_err);
                if (!r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_fail_a     <= bus.a_in;
                    r_fail_b     <= bus.b_in;
                    r_fail_mode  <= bus.mode_in;
                end
            end
        end
    end

    assign bus.busy_out       = r_state == RUN;
    assign bus.done_out       = r_state == DONE;
    assign bus.pass_out       = (r_state == DONE) && (r_err == '0);
    assign bus.vec_count_out  = r_vec;
    assign bus.err_count_out  = r_err;
    assign bus.fail_valid_out = r_fail_valid;
    assign bus.fail_a_out     = r_fail_a;
    assign bus.fail_b_out     = r_fail_b;
    assign bus.fail_mode_out  = r_fail_mode;

endmodule

// File: tb/tb_addsub_result_checker.sv
// tb_addsub_result_checker: drives two checkers (STOP_ON_FAIL 0 and 1) with directed and
// random vectors and compares every output against an arithmetic reference model.
module tb_addsub_result_checker;

`ifdef ADDSUB_CHK_SEQ_EN
    localparam int SEQ = 1;
`else
    localparam int SEQ = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addsub_result_checker_if #(.WIDTH(4)) bus0();
    addsub_result_checker_if #(.WIDTH(4)) bus1();

    addsub_result_checker #(.WIDTH(4), .STOP_ON_FAIL(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    addsub_result_checker #(.WIDTH(4), .STOP_ON_FAIL(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_checks = 0;
    int n_errors = 0;

    int m_run[2], m_done[2], m_vec[2], m_err[2], m_fv[2], m_fa[2], m_fb[2], m_fm[2];
    bit s_st, s_v, s_m, s_c, s_br;
    int s_a, s_b, s_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_calc(input int a, input int b, input bit m,
                                     output int o, output bit c, output bit br);
        if (!m) begin
            o = (a + b) % 16; c = (a + b) > 15; br = 1'b0;
        end else begin
            o = (a - b + 16) % 16; c = 1'b0; br = a < b;
        end
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 0; m_done[d] = 0; m_vec[d] = 0; m_err[d] = 0;
            m_fv[d] = 0; m_fa[d] = 0; m_fb[d] = 0; m_fm[d] = 0;
        end
    endtask

    task automatic model_update();
        int eo; bit ec, eb, bad;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ref_calc(s_a, s_b, s_m, eo, ec, eb);
        bad = (eo != s_o) || (ec != s_c) || (eb != s_br);
        for (int d = 0; d < 2; d++) begin
            if (s_st) begin
                m_run[d] = 1; m_done[d] = 0; m_vec[d] = 0; m_err[d] = 0;
                m_fv[d] = 0; m_fa[d] = 0; m_fb[d] = 0; m_fm[d] = 0;
            end else if (m_run[d] && s_v) begin
                bit vbad;
                vbad = bad || (SEQ != 0 && (s_a * 32 + s_b * 2 + int'(s_m)) != m_vec[d] % 512);
                m_vec[d]++;
                if (vbad) begin
                    if (m_err[d] < 65535) m_err[d]++;
                    if (!m_fv[d]) begin
                        m_fv[d] = 1; m_fa[d] = s_a; m_fb[d] = s_b; m_fm[d] = s_m;
                    end
                end
                if (m_vec[d] == 512 || (d == 1 && vbad)) begin
                    m_run[d] = 0; m_done[d] = 1;
                end
            end
        end
    endtask

    task automatic cmp_dut(input int d, input logic busy, input logic done, input logic pass,
                           input logic [9:0] vec, input logic [15:0] err, input logic fv,
                           input logic [3:0] fa, input logic [3:0] fb, input logic fm);
        chk($sformatf("busy%0d", d), busy, m_run[d]);
        chk($sformatf("done%0d", d), done, m_done[d]);
        chk($sformatf("pass%0d", d), pass, m_done[d] && m_err[d] == 0);
        chk($sformatf("vec%0d", d), vec, m_vec[d]);
        chk($sformatf("err%0d", d), err, m_err[d]);
        chk($sformatf("fail_valid%0d", d), fv, m_fv[d]);
        chk($sformatf("fail_a%0d", d), fa, m_fa[d]);
        chk($sformatf("fail_b%0d", d), fb, m_fb[d]);
        chk($sformatf("fail_mode%0d", d), fm, m_fm[d]);
    endtask

    task automatic compare_all();
        cmp_dut(0, bus0.busy_out, bus0.done_out, bus0.pass_out, bus0.vec_count_out, bus0.err_count_out,
                bus0.fail_valid_out, bus0.fail_a_out, bus0.fail_b_out, bus0.fail_mode_out);
        cmp_dut(1, bus1.busy_out, bus1.done_out, bus1.pass_out, bus1.vec_count_out, bus1.err_count_out,
                bus1.fail_valid_out, bus1.fail_a_out, bus1.fail_b_out, bus1.fail_mode_out);
    endtask

    // Inputs change 1 time unit after the edge; outputs are compared 1 unit after the edge.
    task automatic drive_raw(input bit st, input bit v, input int a, input int b, input bit m,
                             input int o, input bit c, input bit br);
        s_st = st; s_v = v; s_a = a; s_b = b; s_m = m; s_o = o; s_c = c; s_br = br;
        bus0.start_in = st; bus0.valid_in = v; bus0.a_in = 4'(a); bus0.b_in = 4'(b);
        bus0.mode_in = m; bus0.out_in = 4'(o); bus0.carry_in = c; bus0.borrow_in = br;
        bus1.start_in = st; bus1.valid_in = v; bus1.a_in = 4'(a); bus1.b_in = 4'(b);
        bus1.mode_in = m; bus1.out_in = 4'(o); bus1.carry_in = c; bus1.borrow_in = br;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit st, input bit v, input int a, input int b, input bit m, input bit fault);
        int o; bit c, br;
        ref_calc(a, b, m, o, c, br);
        if (fault) begin
            case ($urandom_range(0, 2))
                0: o = o ^ int'($urandom_range(1, 15));
                1: c = ~c;
                default: br = ~br;
            endcase
        end
        drive_raw(st, v, a, b, m, o, c, br);
    endtask

    task automatic drive_idx(input int idx, input bit fault);
        drive(1'b0, 1'b1, idx >> 5, (idx >> 1) & 15, idx[0], fault);
    endtask

    initial begin
        model_reset();
        drive_raw(0, 0, 0, 0, 0, 0, 0, 0);
        drive_raw(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            drive(0, 1, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom), 1'($urandom));

        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 512; i++)
            drive_idx(i, 0);
        chk("sweep_done", bus0.done_out, 1);
        chk("sweep_pass", bus0.pass_out, 1);
        chk("sweep_vec", bus0.vec_count_out, 512);
        chk("sweep_busy", bus0.busy_out, 0);
        for (int i = 0; i < 3; i++)
            drive(0, 1, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom), 1);

        drive(1, 0, 0, 0, 0, 0);
        drive_raw(0, 1, 9, 12, 1, 13, 0, 0);
        chk("fault_err", bus0.err_count_out, 1);
        chk("fault_a", bus0.fail_a_out, 9);
        chk("fault_b", bus0.fail_b_out, 12);
        chk("fault_mode", bus0.fail_mode_out, 1);
        chk("stop_after_fault", bus1.done_out, 1);
        drive_raw(0, 1, 15, 1, 0, 0, 1, 0);
        chk("carry_ok_err", bus0.err_count_out, 1 + SEQ);
        drive_raw(0, 1, 15, 1, 0, 0, 0, 0);
        chk("carry_bad_err", bus0.err_count_out, 2 + SEQ);
        chk("fault_pass", bus0.pass_out, 0);

        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++)
            drive_idx(i, 0);
        drive_idx(100, 1);
        chk("stop_done", bus1.done_out, 1);
        chk("stop_vec", bus1.vec_count_out, 101);
        chk("nostop_busy", bus0.busy_out, 1);
        for (int i = 101; i <= 200; i++)
            drive_idx(i, 0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("areset_busy", bus0.busy_out, 0);
        chk("areset_vec", bus0.vec_count_out, 0);
        chk("areset_err", bus0.err_count_out, 0);
        chk("areset_fv", bus0.fail_valid_out, 0);
        compare_all();
        drive(0, 1, 3, 4, 0, 0);
        rst_n = 1'b1;

        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            drive_idx(i, 1);
        drive_idx(3, 0);
        drive(1, 1, 0, 0, 0, 1);
        chk("restart_vec", bus0.vec_count_out, 0);
        chk("restart_err", bus0.err_count_out, 0);
        chk("restart_fv", bus0.fail_valid_out, 0);
        chk("restart_busy", bus0.busy_out, 1);
        drive_idx(0, 0);
        chk("after_restart_vec", bus0.vec_count_out, 1);
        chk("after_restart_err", bus0.err_count_out, 0);

        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 512; i++)
            drive_idx(i == 5 ? 6 : i == 6 ? 5 : i, 0);
        chk("swap_err", bus0.err_count_out, 2 * SEQ);
        chk("swap_done", bus0.done_out, 1);

        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0)
                drive(1, 1'($urandom), 0, 0, 0, 0);
            else
                drive(0, $urandom_range(0, 7) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
                      1'($urandom), $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/addsub_result_checker.md
# addsub_result_checker

Synthesizable self-checking monitor for the 4-bit adder/subtractor. It consumes the operand/result stream that a stimulus source drives into the adder/subtractor. It recomputes the expected sum/difference, carry and borrow, then counts vectors and mismatches and captures the first failing vector. It is the receiving end of the exhaustive a/b/mode sweep, for on-chip or FPGA regression where no simulator checker is available.

## Interface
- WIDTH, 4, operand/result width
- STOP_ON_FAIL, 0, 1 = end the run at the first mismatch
- localparam VEC_COUNT = 2^(2*WIDTH+1) (512 at default), vectors per full sweep
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- One clock; reset is asynchronous and active-low.
- start_in  input  1  begin or restart a run; clears counters
- valid_in  input  1  the current vector is sampled this cycle
- a_in, b_in  input  WIDTH  operands as driven to the DUT
- mode_in  input  1  0 = add, 1 = subtract
- out_in  input  WIDTH  DUT result
- carry_in, borrow_in  input  1  DUT carry_out / borrow_out
- busy_out  output  1  run in progress
- done_out  output  1  run finished (sticky until start_in)
- pass_out  output  1  done and zero errors
- vec_count_out  output  2*WIDTH+2  vectors accepted this run
- err_count_out  output  16  mismatching vectors (saturating)
- fail_valid_out  output  1  first-fail capture holds data
- fail_a_out, fail_b_out  output  WIDTH  operands of the first failing vector
- fail_mode_out  output  1  mode of the first failing vector

## Operation
- Expected model, mode 0: out = (a+b) mod 2^WIDTH; carry = bit WIDTH of the (WIDTH+1)-bit sum; borrow = 0.
- Expected model, mode 1: out = (a−b) mod 2^WIDTH; borrow = (a < b) unsigned; carry = 0.
- A vector mismatches if any of out/carry/borrow differs from the model.
- FSM states IDLE, RUN, DONE.
  - IDLE: valid_in ignored. start_in → RUN.
  - RUN: each valid_in increments vec_count. On a mismatch it increments err_count (saturating at 0xFFFF). On the first mismatch it loads the fail_* registers and sets fail_valid.
  - RUN exits to DONE when vec_count reaches VEC_COUNT, or on the first mismatch if STOP_ON_FAIL=1.
  - DONE: outputs held, valid_in ignored. start_in → RUN.
- start_in in any state clears vec_count, err_count and the fail_* registers, and enters RUN.
- start_in and valid_in in the same cycle: start wins and the vector is dropped.
- The vector that completes the count is itself checked before DONE.
- pass_out = done & (err_count == 0).

## Timing
- Reset: state IDLE; busy, done, pass and fail_valid = 0; counters and fail_* = 0.
- All outputs are registered. A vector sampled at edge N is reflected in the counters and fail_* after edge N.
- busy_out rises the cycle after start_in.
- done_out and pass_out rise in the cycle after the final vector is sampled, and busy_out falls in that same cycle.
- Back-to-back valid_in every cycle is supported; there are no stall or ready signals.
- An asynchronous reset mid-run aborts immediately. All state returns to reset values and nothing is retained.

## Configuration
- ADDSUB_CHK_SEQ_EN defined: adds a sweep-order check.
  - Expected index = a·2^(WIDTH+1) + b·2 + mode, starting at 0 after start_in and advancing by 1 per accepted vector.
  - A vector whose {a,b,mode} differs from the expected index counts as a mismatch, even if the result is correct.
  - The index counter wraps to 0 after VEC_COUNT−1.
- Undefined: no order check, and vectors may arrive in any order.

## Structure
- Package addsub_chk_pkg:
  - state enum {IDLE, RUN, DONE}
  - error-counter width constant (16)
  - function computing expected {out, carry, borrow} from a, b, mode
- Sub-module addsub_ref_model: purely combinational golden model (WIDTH-parameterized) instanced once. The checker top holds the FSM, counters and capture registers.

## Test plan
- Clean sweep: start_in, then all 512 vectors in i/j/k order with correct results, one per cycle → done_out=1, pass_out=1, vec_count=512, err_count=0, fail_valid=0.
- Single fault: a=9, b=12, mode=1, out forced to 0xD, borrow=0 (correct is out=0xD, borrow=1) → err_count=1, fail_a=9, fail_b=12, fail_mode=1, pass_out=0.
- Add carry boundary: a=15, b=1, mode=0, out=0, carry=1 → no error; the same vector with carry=0 → error.
- STOP_ON_FAIL=1: fault injected at vector 100 → done_out the cycle after it, vec_count=101.
- Restart: start_in mid-run after 3 errors → counters cleared to 0, fail_valid=0, busy stays 1. start_in together with valid_in → that vector is not counted.
- Async reset asserted mid-run at vector 200 → all outputs 0 immediately. With ADDSUB_CHK_SEQ_EN, swapping vectors 5 and 6 → err_count=2.
